down_sampler_m_1: RTL

Parametrised M:1 decimator for the signed sample stream, gated by the sample-rate enable clk_en.
- Keeps one sample in every DECIM accepted samples, at a runtime-selectable phase.
- Flags each output with a one-cycle valid pulse.
- Sits between the upstream filter stage and the downstream rate-reduced datapath; generalises the 2:1 pass-through sampler.

---
 rtl/dsp_pkg.sv | 23 ++
 rtl/decim_phase_counter.sv | 51 +++++
 rtl/down_sampler_m_1.sv | 105 ++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the sample-rate blocks.
// - sample_t / DATA_W_DEFAULT : default signed sample format
// - clog2()                   : ceil(log2(v)), usable in parameter defaults
// - clamp_phase()             : folds an out-of-range phase onto the last slot
package dsp_pkg;

    localparam int DATA_W_DEFAULT = 18;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Phase values past the end of the frame select the last sample.
    function automatic int clamp_phase(input int p, input int decim);
        return (p >= decim) ? decim - 1 : p;
    endfunction

endpackage

// File: rtl/decim_phase_counter.sv
// Frame position tracker for the M:1 decimator.
// Owns the sample counter, sync re-alignment and the latched (clamped) phase.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clk_en         - sample accept strobe
//   sync_in        - forces the current sample to frame index 0
//   phase          - requested keep-index (clamped to DECIM-1)
//   idx            - frame index of the sample presented this cycle
//   sel            - high when this cycle's accepted sample is the kept one
module decim_phase_counter
    import dsp_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int CNT_W = clog2(DECIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             sync_in,
    input  logic [CNT_W-1:0] phase,
    output logic [CNT_W-1:0] idx,
    output logic             sel
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_c;

    assign phase_c = CNT_W'(clamp_phase(int'(phase), DECIM));
    assign idx     = sync_in ? '0 : counter;
    // Selection uses the phase latched at the frame boundary, so a phase
    // change mid-frame only takes effect from the next frame.
    assign sel     = clk_en && (idx == phase_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            phase_q <= phase_c;
        end else begin
            if (clk_en)
                counter <= (idx == LAST) ? '0 : idx + CNT_W'(1);
            else if (sync_in)
                counter <= '0;
            if (sync_in || (clk_en && (idx == LAST)))
                phase_q <= phase_c;
        end
    end

endmodule

// File: rtl/down_sampler_m_1.sv
// M:1 decimator for a signed sample stream gated by clk_en.
// Base mode keeps one accepted sample per DECIM at a runtime phase.
// Define DOWN_SAMPLER_AVG_EN for boxcar mode: each output is the floor mean
// of the DECIM samples of a frame (DECIM must then be a power of two).
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   clk_en     - input sample strobe
//   sync_in    - re-align pulse, current accepted sample becomes index 0
//   phase      - index of the sample kept per frame (base mode only)
//   x_in       - signed input sample
//   y          - registered decimated sample
//   y_valid    - one-cycle pulse in the cycle y updates
module down_sampler_m_1
    import dsp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DECIM  = 4,
    parameter int CNT_W  = clog2(DECIM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              sync_in,
    input  logic [CNT_W-1:0]  phase,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] y,
    output logic              y_valid
);

    if (DECIM < 2 || DECIM > 256) begin : g_bad_decim
        $error("down_sampler_m_1: DECIM out of range 2..256");
    end

    logic [CNT_W-1:0] idx;
    logic             sel;

    decim_phase_counter #(
        .DECIM (DECIM),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .sync_in (sync_in),
        .phase   (phase),
        .idx     (idx),
        .sel     (sel)
    );

`ifdef DOWN_SAMPLER_AVG_EN

    if ((1 << CNT_W) != DECIM) begin : g_bad_pow2
        $error("down_sampler_m_1: boxcar mode needs DECIM a power of two");
    end

    localparam int               ACC_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DECIM - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    last;
    logic                    unused_sel;

    assign unused_sel = sel;
    assign x_ext      = $signed({{CNT_W{x_in[DATA_W-1]}}, x_in});
    // Index 0 starts a fresh sum, which also covers a sync re-alignment.
    assign acc_sum    = ((idx == '0) ? '0 : acc) + x_ext;
    assign last       = clk_en && (idx == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= last;
            if (clk_en)
                acc <= acc_sum;
            // Dropping the low CNT_W bits is the arithmetic shift (floor).
            if (last)
                y <= acc_sum[ACC_W-1:CNT_W];
        end
    end

`else

    logic unused_idx;

    assign unused_idx = ^idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= sel;
            if (sel)
                y <= x_in;
        end
    end

`endif

endmodule
